seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed seven-segment display driver; sits directly downstream of the digit-value timer.
- Generates the active-low digit enables that the timer uses to select which nibble it presents on num.
- Samples that nibble, decodes it to an active-low segment pattern and drives the board display.
- Inserts a blanking gap at every digit switch so the combinational num path settles before segments light (no ghosting).

Parameters:
- NUM_DIGITS, 2, number of scanned digits (1..8); digit 0 maps to the timer's en0, digit 1 to en1.
- SCAN_CNT, 200000, clk cycles per digit slot including blank (2 ms at 100 MHz); must be > BLANK_CNT+2.
- BLANK_CNT, 1000, clk cycles at the start of each slot with all digits and segments off.
- CNT_W, 18, width of the slot counter; must satisfy 2^CNT_W > SCAN_CNT.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-high reset.
- disp_on  in  1  1 = scan active; 0 = display dark.
- num  in  4  hex value of the currently enabled digit, combinational from the timer.
- dp_mask  in  NUM_DIGITS  per-digit decimal point request, 1 = lit.
- led_en  out  NUM_DIGITS  active-low digit enables, registered; bit i feeds timer en<i>.
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
- dig_idx  out  3  index of the digit owning the current slot, registered.

Behaviour:
- Reset (async, rst=1): state=OFF, slot counter=0, dig_idx=0, led_en=all 1, seg=8'hFF. Outputs hold these values while rst is high, including mid-slot.
- Single FSM, states OFF, BLANK, SHOW. Slot counter counts 0..SCAN_CNT-1 and then wraps to 0.
- OFF:
  - led_en all 1, seg 8'hFF, counter held at 0.
  - disp_on=1 moves to BLANK next cycle with dig_idx=0.
- BLANK:
  - led_en all 1, seg 8'hFF; counter increments.
  - When counter reaches BLANK_CNT-1, move to SHOW; led_en[dig_idx] goes 0 in the first SHOW cycle.
- SHOW:
  - led_en = ~(1<<dig_idx).
  - Each cycle, seg <= ~{dp_mask[dig_idx], decode(num)}. seg therefore lags num by exactly 1 cycle.
  - First lit segment pattern appears the cycle after led_en asserts, while the timer has already switched num.
  - When counter reaches SCAN_CNT-1: counter <= 0, dig_idx <= (dig_idx==NUM_DIGITS-1) ? 0 : dig_idx+1, state <= BLANK. led_en and seg go dark in that same edge.
- Decode (a..g, 1 = lit before inversion): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- disp_on deasserted in any state:
  - Next cycle: state=OFF, counter=0, dig_idx=0, all dark.
  - Re-enable always restarts from digit 0 with a full blank window.
- disp_on=0 and a slot wrap in the same cycle: OFF takes priority.
- dp_mask and num are sampled every SHOW cycle, so mid-slot changes appear on seg 1 cycle later.
- Never more than one led_en bit low. All led_en high throughout BLANK and OFF.
- NUM_DIGITS=1: dig_idx stays 0; the BLANK/SHOW cycle still runs.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_OFF = 8'hFF.
  - The 16-entry hex-to-segment constant table.
  - Default timing constants for 100 MHz: SCAN_CNT and BLANK_CNT.
- One natural sub-module, seg_hex_decode: purely combinational, 4-bit in to 7-bit active-high out. The parent handles inversion and dp.

Test Plan (SCAN_CNT=10, BLANK_CNT=3, NUM_DIGITS=2, bench models timer num = en0 low ? 4'h7 : 4'h1):
- Reset: rst=1 mid-SHOW -> led_en=2'b11, seg=8'hFF and dig_idx=0 in the same cycle, without waiting for a clock edge. After release with disp_on=0 -> all stay dark indefinitely.
- Basic scan: disp_on=1 -> 3 dark cycles, then led_en=2'b10 for 7 cycles. seg=8'hF8 (7) from the 2nd lit cycle. Then 3 dark cycles, led_en=2'b01 for 7 cycles with seg=8'hF9 (1), then wrap to digit 0.
- Decode sweep: force num 0..F during SHOW, dp_mask=0 -> seg matches the inverted table each following cycle. dp_mask[0]=1 with num=8 -> seg=8'h00.
- Mid-slot disable: drop disp_on at cycle 5 of digit 1 -> next cycle all dark. Re-assert -> restart at digit 0 after 3 blank cycles.
- Simultaneous disable and wrap: disp_on=0 on counter=9 -> OFF with dig_idx=0, not BLANK on digit 1.
- Invariant check over 1000 random cycles with random disp_on/num/dp_mask -> popcount(~led_en) <= 1 always, and seg=8'hFF whenever led_en=all 1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Holds the hex-to-segment table, the dark pattern and default 100 MHz timing.
package seg_pkg;

  // Active-low segment byte with everything off.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Default slot timing at 100 MHz: 2 ms per digit, 10 us of blanking.
  localparam int SCAN_CNT_DEF  = 200000;
  localparam int BLANK_CNT_DEF = 1000;

  // Active-high a..g patterns, bit 0 = a. Entry n lives at HEX_SEG[n],
  // so the concatenation below is listed from F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of the scan driver: control in, timer nibble in,
// digit enables / segments / digit index out.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 2
);
  logic                  disp_on;
  logic [3:0]            num;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [NUM_DIGITS-1:0] led_en;
  logic [7:0]            seg;
  logic [2:0]            dig_idx;

  // The driver itself.
  modport master (
    input  disp_on, num, dp_mask,
    output led_en, seg, dig_idx
  );

  // The surroundings: control logic, digit-value timer and the board.
  modport slave (
    output disp_on, num, dp_mask,
    input  led_en, seg, dig_idx
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high a..g segment decode.
// Inversion and decimal point are left to the parent.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] num,
  output logic [6:0] seg_abc
);

  assign seg_abc = HEX_SEG[num];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_OFF   | display dark, counter and digit index parked at 0
// S_BLANK | start of a slot: all digits off while the timer's num settles
// S_SHOW  | owning digit enabled; segments track num with one cycle of lag
//
// The slot counter runs 0..SCAN_CNT-1 across BLANK and SHOW of one digit.
// led_en feeds the timer's digit selects, so num only reflects the new digit
// once led_en has switched; seg is therefore loaded one cycle after led_en
// asserts, and the first SHOW cycle still shows dark segments.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_CNT   = SCAN_CNT_DEF,
  parameter int BLANK_CNT  = BLANK_CNT_DEF,
  parameter int CNT_W      = 18
) (
  input logic              clk,
  input logic              rst,
  seg_scan_driver_if.master bus
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CNT - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CNT - 1);
  localparam logic [2:0]       DIG_LAST   = 3'(NUM_DIGITS - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            dig_q, dig_d;
  logic [NUM_DIGITS-1:0] led_q, led_d;
  logic [7:0]            seg_q, seg_d;

  logic [6:0]            seg_abc;
  logic                  dp_sel;
  logic [NUM_DIGITS-1:0] led_show;

  seg_hex_decode u_hex_decode (
    .num     (bus.num),
    .seg_abc (seg_abc)
  );

  // Per-digit view of the current index: one-cold enable and its dp request.
  always_comb begin
    dp_sel   = 1'b0;
    led_show = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q == 3'(i)) begin
        dp_sel      = bus.dp_mask[i];
        led_show[i] = 1'b0;
      end
    end
  end

  // Next state, counter, digit index and output registers; disable wins last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    led_d   = '1;
    seg_d   = SEG_OFF;

    unique case (state_q)
      S_OFF: begin
        cnt_d = '0;
        dig_d = '0;
        if (bus.disp_on) begin
          state_d = S_BLANK;
        end
      end

      S_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          led_d   = led_show;
        end
      end

      S_SHOW: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d   = '0;
          dig_d   = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
          state_d = S_BLANK;
        end else begin
          cnt_d = cnt_q + 1'b1;
          led_d = led_show;
          seg_d = ~{dp_sel, seg_abc};
        end
      end

      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        dig_d   = '0;
      end
    endcase

    // Turning the display off overrides everything, including a slot wrap,
    // so a re-enable always begins at digit 0 with a full blank window.
    if (!bus.disp_on) begin
      state_d = S_OFF;
      cnt_d   = '0;
      dig_d   = '0;
      led_d   = '1;
      seg_d   = SEG_OFF;
    end
  end

  // State and output registers, all dark while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      dig_q   <= '0;
      led_q   <= '1;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.led_en  = led_q;
  assign bus.seg     = seg_q;
  assign bus.dig_idx = dig_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with short slot timing.
// The reference model tracks cycles since enable and derives slot, digit
// and blanking from plain division and remainder.
module tb_seg_scan_driver;

  localparam int ND = 2;
  localparam int SC = 10;
  localparam int BC = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  logic       force_num = 1'b0;
  logic [3:0] num_val   = 4'h0;

  // Digit-value timer stand-in: presents 7 while digit 0 is enabled, else 1.
  assign bus.num = force_num ? num_val : ((bus.led_en[0] == 1'b0) ? 4'h7 : 4'h1);

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_CNT   (SC),
    .BLANK_CNT  (BC),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tbl [16];

  bit             m_on = 1'b0;
  int             m_p  = 0;
  logic [ND-1:0]  exp_led;
  logic [7:0]     exp_seg;
  logic [2:0]     exp_dig;

  // Advance one clock: sample inputs, update the model, then settle after the edge.
  task automatic step();
    logic [3:0]    n_s;
    logic [ND-1:0] d_s;
    int            off;
    int            dig;
    #1;
    n_s = bus.num;
    d_s = bus.dp_mask;
    if (!bus.disp_on) m_on = 1'b0;
    else if (!m_on) begin
      m_on = 1'b1;
      m_p  = 0;
    end else m_p++;
    @(posedge clk);
    #1;
    off     = m_p % SC;
    dig     = (m_p / SC) % ND;
    exp_led = '1;
    exp_seg = 8'hFF;
    exp_dig = 3'd0;
    if (m_on) begin
      exp_dig = 3'(dig);
      if (off >= BC) exp_led[dig] = 1'b0;
      if (off > BC)  exp_seg = ~{d_s[dig], seg_tbl[n_s]};
    end
  endtask

  task automatic test_reset();
    bus.disp_on = 1'b0;
    bus.dp_mask = '0;
    #12;
    n_checks++;
    if (bus.led_en !== 2'b11 || bus.seg !== 8'hFF || bus.dig_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_hold got led=%b seg=%h dig=%0d exp led=11 seg=ff dig=0",
               bus.led_en, bus.seg, bus.dig_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.disp_on = 1'b1;
    m_on = 1'b0;
    repeat (15) step();
    n_checks++;
    if (bus.led_en !== exp_led || bus.dig_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_pre got led=%b dig=%0d exp led=%b dig=1", bus.led_en, bus.dig_idx, exp_led);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.led_en !== 2'b11 || bus.seg !== 8'hFF || bus.dig_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_async got led=%b seg=%h dig=%0d exp led=11 seg=ff dig=0",
               bus.led_en, bus.seg, bus.dig_idx);
    end
    m_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.disp_on = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (bus.led_en !== 2'b11 || bus.seg !== 8'hFF || bus.dig_idx !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_dark cyc=%0d got led=%b seg=%h dig=%0d exp dark", i,
                 bus.led_en, bus.seg, bus.dig_idx);
      end
    end
  endtask

  task automatic test_basic_scan();
    bus.disp_on = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      n_checks++;
      if (bus.led_en !== exp_led || bus.seg !== exp_seg || bus.dig_idx !== exp_dig) begin
        n_fail++;
        $display("FAIL basic_scan p=%0d got led=%b seg=%h dig=%0d exp led=%b seg=%h dig=%0d",
                 m_p, bus.led_en, bus.seg, bus.dig_idx, exp_led, exp_seg, exp_dig);
      end
    end
  endtask

  task automatic test_decode_sweep();
    bus.disp_on = 1'b0;
    step();
    bus.disp_on = 1'b1;
    bus.dp_mask = '0;
    force_num   = 1'b1;
    for (int k = 0; k < 48; k++) begin
      num_val = 4'(k % 16);
      step();
      n_checks++;
      if (bus.seg !== exp_seg || bus.led_en !== exp_led) begin
        n_fail++;
        $display("FAIL decode_sweep k=%0d got seg=%h led=%b exp seg=%h led=%b",
                 k, bus.seg, bus.led_en, exp_seg, exp_led);
      end
    end
    bus.disp_on = 1'b0;
    step();
    bus.dp_mask = 2'b01;
    num_val     = 4'h8;
    bus.disp_on = 1'b1;
    repeat (5) step();
    n_checks++;
    if (bus.seg !== 8'h00 || bus.led_en !== 2'b10) begin
      n_fail++;
      $display("FAIL decode_dp8 got seg=%h led=%b exp seg=00 led=10", bus.seg, bus.led_en);
    end
    force_num   = 1'b0;
    bus.dp_mask = '0;
  endtask

  task automatic test_mid_disable();
    bus.disp_on = 1'b0;
    step();
    bus.disp_on = 1'b1;
    repeat (16) step();
    bus.disp_on = 1'b0;
    step();
    n_checks++;
    if (bus.led_en !== 2'b11 || bus.seg !== 8'hFF || bus.dig_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_disable got led=%b seg=%h dig=%0d exp dark dig=0",
               bus.led_en, bus.seg, bus.dig_idx);
    end
    bus.disp_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus.led_en !== exp_led || bus.seg !== exp_seg || bus.dig_idx !== exp_dig) begin
        n_fail++;
        $display("FAIL mid_reenable p=%0d got led=%b seg=%h dig=%0d exp led=%b seg=%h dig=%0d",
                 m_p, bus.led_en, bus.seg, bus.dig_idx, exp_led, exp_seg, exp_dig);
      end
    end
    n_checks++;
    if (bus.led_en !== 2'b10 || bus.dig_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_restart_d0 got led=%b dig=%0d exp led=10 dig=0", bus.led_en, bus.dig_idx);
    end
  endtask

  task automatic test_disable_on_wrap();
    bus.disp_on = 1'b0;
    step();
    bus.disp_on = 1'b1;
    repeat (10) step();
    bus.disp_on = 1'b0;
    step();
    n_checks++;
    if (bus.led_en !== 2'b11 || bus.seg !== 8'hFF || bus.dig_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_disable got led=%b seg=%h dig=%0d exp dark dig=0",
               bus.led_en, bus.seg, bus.dig_idx);
    end
    bus.disp_on = 1'b1;
    repeat (4) step();
    n_checks++;
    if (bus.led_en !== 2'b10 || bus.dig_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_restart got led=%b dig=%0d exp led=10 dig=0", bus.led_en, bus.dig_idx);
    end
  endtask

  task automatic test_random();
    force_num = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.disp_on = ($urandom_range(0, 19) != 0);
      num_val     = 4'($urandom);
      bus.dp_mask = ND'($urandom);
      step();
      n_checks++;
      if (bus.led_en !== exp_led || bus.seg !== exp_seg || bus.dig_idx !== exp_dig) begin
        n_fail++;
        $display("FAIL random_model i=%0d got led=%b seg=%h dig=%0d exp led=%b seg=%h dig=%0d",
                 i, bus.led_en, bus.seg, bus.dig_idx, exp_led, exp_seg, exp_dig);
      end
      n_checks++;
      if ($countones(~bus.led_en) > 1) begin
        n_fail++;
        $display("FAIL random_onecold i=%0d got led=%b exp at most one low", i, bus.led_en);
      end
      n_checks++;
      if (bus.led_en === 2'b11 && bus.seg !== 8'hFF) begin
        n_fail++;
        $display("FAIL random_dark_seg i=%0d got seg=%h exp ff", i, bus.seg);
      end
    end
    force_num = 1'b0;
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    test_reset();
    test_basic_scan();
    test_decode_sweep();
    test_mid_disable();
    test_disable_on_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
